// File: rtl/sine_voice_sched_pkg.sv
// Shared types and widths for the sine voice scheduler.
package sine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int LUT_PHASE_W = 16;
   localparam int LUT_MAG_W   = 15;
   localparam int SAMPLE_W    = 16;

endpackage

// File: rtl/sine_voice_sched_if.sv
// Config, lookup-path and sample-output signals of the voice scheduler.
interface sine_voice_sched_if
   import sine_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24
);
   localparam int VW = $clog2(NUM_VOICES);

   logic                   i_sample_tick;
   logic                   i_cfg_we;
   logic [VW-1:0]          i_cfg_voice;
   logic [PHASE_W-1:0]     i_cfg_inc;
   logic                   i_cfg_en;
   logic                   i_cfg_phase_clr;
   logic [LUT_PHASE_W-1:0] o_lut_phase;
   logic                   o_lut_req;
   logic [LUT_MAG_W-1:0]   i_lut_mag;
   logic [SAMPLE_W-1:0]    o_sample;
   logic [VW-1:0]          o_voice;
   logic                   o_valid;
   logic                   o_busy;
   logic                   o_overrun;

   modport master (
      output i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_inc, i_cfg_en, i_cfg_phase_clr,
      output i_lut_mag,
      input  o_lut_phase, o_lut_req, o_sample, o_voice, o_valid, o_busy, o_overrun
   );

   modport slave (
      input  i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_inc, i_cfg_en, i_cfg_phase_clr,
      input  i_lut_mag,
      output o_lut_phase, o_lut_req, o_sample, o_voice, o_valid, o_busy, o_overrun
   );

endinterface

// File: rtl/sine_voice_sched_tag_pipe.sv
// Shift register that delays each issue tag to line up with the ROM magnitude.
module sine_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] stage [DEPTH];

   // shift one stage per clock; reset flushes any in-flight tags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/sine_voice_sched.sv
// Time-multiplexed phase accumulators sharing one quarter-wave sine lookup.
//
// state | meaning
// IDLE  | waiting for a sample tick
// ISSUE | one voice per cycle, ascending, sent to the lookup path
// DRAIN | waiting LUT_LAT+1 cycles for the last sample to come out
module sine_voice_sched
   import sine_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24,
   parameter int LUT_LAT    = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   sine_voice_sched_if.slave bus
);

   localparam int VW = $clog2(NUM_VOICES);
   localparam int CW = $clog2(LUT_LAT + 1);

   state_t             state, state_nxt;
   logic [VW-1:0]      idx, idx_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;

   logic [PHASE_W-1:0] inc_r   [NUM_VOICES];
   logic [PHASE_W-1:0] phase_r [NUM_VOICES];
   logic [NUM_VOICES-1:0] en_r;

   logic                   issue;
   logic [LUT_PHASE_W-1:0] cur_phase;
   logic [VW+1:0]          tag_in, tag_q;
   logic                   vld_q;
   logic [SAMPLE_W-1:0]    mag_ext, sample_nxt;
   logic                   overrun_q, valid_q;
   logic [VW-1:0]          voice_q;
   logic [SAMPLE_W-1:0]    sample_q;

   assign issue     = (state == ISSUE);
   assign cur_phase = phase_r[idx][PHASE_W-1 -: LUT_PHASE_W];

   // state register with issue index and drain down-counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next-state: ISSUE walks all voices, DRAIN counts LUT_LAT down to 0
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.i_sample_tick) begin
               state_nxt = ISSUE;
               idx_nxt   = '0;
            end
         end
         ISSUE: begin
            if (idx == VW'(NUM_VOICES - 1)) begin
               state_nxt = DRAIN;
               cnt_nxt   = CW'(LUT_LAT);
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // voice registers; a phase clear wins over the same-cycle accumulate
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NUM_VOICES; k++) begin
            inc_r[k]   <= '0;
            phase_r[k] <= '0;
         end
         en_r <= '0;
      end else begin
         for (int k = 0; k < NUM_VOICES; k++) begin
            if (bus.i_cfg_we && bus.i_cfg_voice == VW'(k)) begin
               inc_r[k] <= bus.i_cfg_inc;
               en_r[k]  <= bus.i_cfg_en;
            end
            if (bus.i_cfg_we && bus.i_cfg_voice == VW'(k) && bus.i_cfg_phase_clr)
               phase_r[k] <= '0;
            else if (issue && idx == VW'(k) && en_r[k])
               phase_r[k] <= phase_r[k] + inc_r[k];
         end
      end
   end

   assign tag_in = {idx, cur_phase[LUT_PHASE_W-1], en_r[idx]};

   sine_tag_pipe #(.DEPTH(LUT_LAT), .W(VW + 2)) u_tag_pipe (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (tag_in),
      .o_q     (tag_q)
   );

   sine_tag_pipe #(.DEPTH(LUT_LAT), .W(1)) u_vld_pipe (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (issue),
      .o_q     (vld_q)
   );

   assign mag_ext    = {1'b0, bus.i_lut_mag};
   assign sample_nxt = !tag_q[0] ? '0 : (tag_q[1] ? -mag_ext : mag_ext);

   // retag the returned magnitude and register the sample outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q   <= 1'b0;
         voice_q   <= '0;
         sample_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= vld_q;
         overrun_q <= bus.i_sample_tick && (state != IDLE);
         if (vld_q) begin
            voice_q  <= tag_q[VW+1:2];
            sample_q <= sample_nxt;
         end
      end
   end

   assign bus.o_lut_req   = issue;
   assign bus.o_lut_phase = issue ? cur_phase : '0;
   assign bus.o_sample    = sample_q;
   assign bus.o_voice     = voice_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_sine_voice_sched.sv
// Directed bench for sine_voice_sched with a two-stage constant-magnitude ROM model.
module tb_sine_voice_sched;
   import sine_pkg::*;

   localparam int NV = 4;
   localparam int PW = 24;
   localparam int LL = 2;
   localparam logic [14:0] ROM_MAG = 15'h1234;
   localparam logic [15:0] SMP_POS = 16'h1234;
   localparam logic [15:0] SMP_NEG = 16'hEDCC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   logic [PW-1:0] inc_m   [NV];
   logic [PW-1:0] phase_m [NV];
   logic [NV-1:0] en_m;
   logic [14:0]   rom_d1, rom_d2;

   sine_voice_sched_if #(.NUM_VOICES(NV), .PHASE_W(PW)) bus ();

   sine_voice_sched #(.NUM_VOICES(NV), .PHASE_W(PW), .LUT_LAT(LL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // ROM model: returns the magnitude two cycles after a request, 0 otherwise
   always @(posedge clk) begin
      rom_d1 <= bus.o_lut_req ? ROM_MAG : 15'h0;
      rom_d2 <= rom_d1;
   end
   assign bus.i_lut_mag = rom_d2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cfg(input int v, input logic [PW-1:0] inc, input logic en, input logic clr);
      @(negedge clk);
      bus.i_cfg_we        = 1'b1;
      bus.i_cfg_voice     = 2'(v);
      bus.i_cfg_inc       = inc;
      bus.i_cfg_en        = en;
      bus.i_cfg_phase_clr = clr;
      @(negedge clk);
      bus.i_cfg_we        = 1'b0;
      bus.i_cfg_phase_clr = 1'b0;
      inc_m[v] = inc;
      en_m[v]  = en;
      if (clr) phase_m[v] = '0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NV; k++) begin
         inc_m[k]   = '0;
         phase_m[k] = '0;
      end
      en_m = '0;
   endtask

   // mode 0: plain scan; 1: extra tick 3 cycles in; 2: clear voice 2 on its issue cycle
   task automatic run_scan(input int mode);
      logic [15:0] ph [NV];
      logic [15:0] smp;
      int          k;
      for (int i = 0; i < NV; i++) ph[i] = phase_m[i][PW-1 -: 16];
      @(negedge clk);
      bus.i_sample_tick = 1'b1;
      @(negedge clk);
      bus.i_sample_tick = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (mode == 1 && c == 3) bus.i_sample_tick = 1'b1;
         if (mode == 1 && c == 4) bus.i_sample_tick = 1'b0;
         if (mode == 2 && c == 3) begin
            bus.i_cfg_we        = 1'b1;
            bus.i_cfg_voice     = 2'd2;
            bus.i_cfg_inc       = inc_m[2];
            bus.i_cfg_en        = en_m[2];
            bus.i_cfg_phase_clr = 1'b1;
         end
         if (mode == 2 && c == 4) begin
            bus.i_cfg_we        = 1'b0;
            bus.i_cfg_phase_clr = 1'b0;
         end
         chk("req", 32'(bus.o_lut_req), 32'(c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) chk("lut_phase", 32'(bus.o_lut_phase), 32'(ph[c-1]));
         chk("busy", 32'(bus.o_busy), 32'(c <= 7));
         chk("overrun", 32'(bus.o_overrun), 32'(mode == 1 && c == 4));
         chk("valid", 32'(bus.o_valid), 32'(c >= 4 && c <= 7));
         if (c >= 4 && c <= 7) begin
            k = c - 4;
            smp = !en_m[k] ? 16'h0 : (ph[k][15] ? SMP_NEG : SMP_POS);
            chk("voice", 32'(bus.o_voice), 32'(k));
            chk("sample", 32'(bus.o_sample), 32'(smp));
         end
         @(negedge clk);
      end
      for (int i = 0; i < NV; i++)
         if (en_m[i]) phase_m[i] = phase_m[i] + inc_m[i];
      if (mode == 2) phase_m[2] = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req"},     32'(bus.o_lut_req),   32'h0);
      chk({tag, "_phase"},   32'(bus.o_lut_phase), 32'h0);
      chk({tag, "_sample"},  32'(bus.o_sample),    32'h0);
      chk({tag, "_voice"},   32'(bus.o_voice),     32'h0);
      chk({tag, "_valid"},   32'(bus.o_valid),     32'h0);
      chk({tag, "_busy"},    32'(bus.o_busy),      32'h0);
      chk({tag, "_overrun"}, 32'(bus.o_overrun),   32'h0);
   endtask

   initial begin
      bus.i_sample_tick   = 1'b0;
      bus.i_cfg_we        = 1'b0;
      bus.i_cfg_voice     = '0;
      bus.i_cfg_inc       = '0;
      bus.i_cfg_en        = 1'b0;
      bus.i_cfg_phase_clr = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      chk_outputs_zero("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // voice 0 steps 0x0040 per scan in the top 16 bits, others disabled
      cfg(0, 24'h004000, 1'b1, 1'b0);
      run_scan(0);
      run_scan(0);
      run_scan(0);

      // voice 1 crosses 0x8000 after two scans; voice 3 wraps downwards
      cfg(1, 24'h400000, 1'b1, 1'b0);
      cfg(3, 24'hFFFFFF, 1'b1, 1'b0);
      run_scan(0);
      run_scan(0);
      run_scan(0);
      run_scan(0);

      // tick while busy is ignored and flagged
      run_scan(1);

      // phase clear on voice 2's issue cycle
      cfg(2, 24'h123400, 1'b1, 1'b0);
      run_scan(0);
      run_scan(2);
      run_scan(0);

      // reset in the middle of ISSUE
      @(negedge clk);
      bus.i_sample_tick = 1'b1;
      @(negedge clk);
      bus.i_sample_tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("post_rst_valid", 32'(bus.o_valid), 32'h0);
         chk("post_rst_busy",  32'(bus.o_busy),  32'h0);
         @(negedge clk);
      end
      run_scan(0);
      cfg(0, 24'h004000, 1'b1, 1'b0);
      cfg(1, 24'h000000, 1'b1, 1'b0);
      run_scan(0);
      run_scan(0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
